// File: rtl/blake_vreg_bank_if.sv
// BLAKE working-state bank bus: control/data toward the bank,
// state and status back. Master drives ops, slave is the bank.
interface blake_vreg_bank_if #(
  parameter int W  = 64,
  parameter int RW = 5
);
  logic            init;
  logic [16*W-1:0] iv;
  logic [15:0]     ld_mask;
  logic [16*W-1:0] din;
  logic            diag;
  logic            undiag;
  logic [16*W-1:0] dout;
  logic            diag_st;
  logic [RW-1:0]   rnd;
  logic            done;
  logic            err;

  modport master (
    output init, iv, ld_mask, din, diag, undiag,
    input  dout, diag_st, rnd, done, err
  );

  modport slave (
    input  init, iv, ld_mask, din, diag, undiag,
    output dout, diag_st, rnd, done, err
  );
endinterface

// File: rtl/blake_vreg_bank.sv
// 16-word BLAKE state bank: init/masked load, row (un)diagonalise,
// round count with done, sticky err. Ports: clk, rstb, bus (slave).
module blake_vreg_bank #(
  parameter int W      = 64,
  parameter int ROUNDS = 16,
  parameter int RW     = 5
) (
  input  logic               clk,
  input  logic               rstb,
  blake_vreg_bank_if.slave   bus
);

  localparam logic [RW-1:0] RMAX = RW'(ROUNDS);

  logic [15:0][W-1:0] v_q, v_d;
  logic [15:0][W-1:0] rl, rr;
  logic [15:0][W-1:0] iv_w, din_w;
  logic               diag_st_q, diag_st_d;
  logic [RW-1:0]      rnd_q, rnd_d;
  logic               err_q, err_d;

  logic op, do_diag, do_undiag, do_ill, do_ld;

  assign iv_w  = bus.iv;
  assign din_w = bus.din;

  // Row r rotates by r words; row 0 maps onto itself.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      assign rl[4*r+j] = v_q[4*r+((j+r)%4)];
      assign rr[4*r+j] = v_q[4*r+((j+4-r)%4)];
    end
  end

  // Mutually exclusive decode so lower priority ops vanish.
  assign do_ld     = !bus.init && (|bus.ld_mask);
  assign op        = !bus.init && !(|bus.ld_mask);
  assign do_diag   = op && bus.diag && !bus.undiag
                     && !diag_st_q;
  assign do_undiag = op && bus.undiag && !bus.diag
                     && diag_st_q;
  assign do_ill    = op && ((bus.diag && bus.undiag)
                     || (bus.diag && diag_st_q)
                     || (bus.undiag && !diag_st_q));

  always_comb begin
    v_d       = v_q;
    diag_st_d = diag_st_q;
    rnd_d     = rnd_q;
    err_d     = err_q;
    unique case (1'b1)
      bus.init: begin
        v_d       = iv_w;
        diag_st_d = 1'b0;
        rnd_d     = '0;
        err_d     = 1'b0;
      end
      do_ld: begin
        for (int k = 0; k < 16; k++)
          if (bus.ld_mask[k]) v_d[k] = din_w[k];
      end
      do_diag: begin
        v_d       = rl;
        diag_st_d = 1'b1;
      end
      do_undiag: begin
        v_d       = rr;
        diag_st_d = 1'b0;
        if (rnd_q != RMAX) rnd_d = rnd_q + 1'b1;
      end
      do_ill: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      v_q       <= '0;
      diag_st_q <= 1'b0;
      rnd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      v_q       <= v_d;
      diag_st_q <= diag_st_d;
      rnd_q     <= rnd_d;
      err_q     <= err_d;
    end
  end

  assign bus.dout    = v_q;
  assign bus.diag_st = diag_st_q;
  assign bus.rnd     = rnd_q;
  assign bus.done    = (rnd_q == RMAX);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_blake_vreg_bank.sv
// Bench for blake_vreg_bank: reference model of the state bank,
// per-cycle compare plus directed literal checks and random ops.
module tb_blake_vreg_bank;
  localparam int W  = 64;
  localparam int RN = 16;

  logic clk = 0;
  logic rstb;
  int   total = 0;
  int   bad   = 0;
  bit   chk   = 0;

  blake_vreg_bank_if #(.W(W), .RW(5)) bus ();

  blake_vreg_bank #(.W(W), .ROUNDS(RN), .RW(5)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] m [16];
  logic [W-1:0] t [16];
  bit           m_dg;
  int           m_rnd;
  bit           m_err;

  // Reference: spec rules applied directly on a word array.
  always @(posedge clk) begin
    if (!rstb) begin
      for (int k = 0; k < 16; k++) m[k] = '0;
      m_dg = 0; m_rnd = 0; m_err = 0;
    end else if (bus.init) begin
      for (int k = 0; k < 16; k++) m[k] = bus.iv[k*W +: W];
      m_dg = 0; m_rnd = 0; m_err = 0;
    end else if (bus.ld_mask != 0) begin
      for (int k = 0; k < 16; k++)
        if (bus.ld_mask[k]) m[k] = bus.din[k*W +: W];
    end else if (bus.diag && bus.undiag) begin
      m_err = 1;
    end else if (bus.diag) begin
      if (m_dg) m_err = 1;
      else begin
        t = m;
        for (int r = 0; r < 4; r++)
          for (int j = 0; j < 4; j++)
            m[4*r+j] = t[4*r + (j+r)%4];
        m_dg = 1;
      end
    end else if (bus.undiag) begin
      if (!m_dg) m_err = 1;
      else begin
        t = m;
        for (int r = 0; r < 4; r++)
          for (int j = 0; j < 4; j++)
            m[4*r + (j+r)%4] = t[4*r+j];
        m_dg = 0;
        if (m_rnd < RN) m_rnd++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      total++;
      for (int k = 0; k < 16; k++)
        if (bus.dout[k*W +: W] !== m[k]) begin
          bad++;
          $display("FAIL dout word %0d act=%h exp=%h",
                   k, bus.dout[k*W +: W], m[k]);
          break;
        end
      total++;
      if (bus.diag_st !== m_dg || bus.rnd !== 5'(m_rnd)
          || bus.done !== (m_rnd == RN)
          || bus.err !== m_err) begin
        bad++;
        $display("FAIL flags act=%b/%0d/%b/%b exp=%b/%0d/%b/%b",
                 bus.diag_st, bus.rnd, bus.done, bus.err,
                 m_dg, m_rnd, m_rnd == RN, m_err);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.init = 0; bus.ld_mask = '0;
    bus.diag = 0; bus.undiag = 0;
  endtask

  task automatic lit(string nm, logic [W-1:0] a,
                     logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] wd(int k);
    return bus.dout[k*W +: W];
  endfunction

  task automatic do_init(int base);
    for (int k = 0; k < 16; k++)
      bus.iv[k*W +: W] = W'(base + k);
    idle(); bus.init = 1;
    cyc(); idle();
  endtask

  task automatic op(bit d, bit u);
    idle(); bus.diag = d; bus.undiag = u;
    cyc(); idle();
  endtask

  initial begin
    rstb = 0;
    bus.init = 1; bus.ld_mask = 16'hFFFF;
    bus.diag = 0; bus.undiag = 0;
    for (int k = 0; k < 16; k++) begin
      bus.iv[k*W +: W]  = {$urandom, $urandom};
      bus.din[k*W +: W] = {$urandom, $urandom};
    end
    cyc(); chk = 1; cyc();
    lit("rst_w0", wd(0), 0);
    lit("rst_w9", wd(9), 0);
    lit("rst_flags", {bus.rnd, bus.done, bus.err,
                      bus.diag_st}, 0);
    rstb = 1;

    do_init(32'h1000);
    lit("init_w5", wd(5), 64'h1005);
    lit("init_rnd", W'(bus.rnd), 0);
    bus.din = '0;
    bus.din[0 +: W]    = 64'hAAAA;
    bus.din[15*W +: W] = 64'h5555;
    bus.ld_mask = 16'h8001;
    cyc(); idle();
    lit("ld_w0", wd(0), 64'hAAAA);
    lit("ld_w15", wd(15), 64'h5555);
    lit("ld_w1", wd(1), 64'h1001);

    do_init(0);
    op(1, 0);
    lit("dg_w12", wd(12), 15);
    lit("dg_w13", wd(13), 12);
    lit("dg_w4", wd(4), 5);
    lit("dg_w7", wd(7), 4);
    lit("dg_st", W'(bus.diag_st), 1);
    op(0, 1);
    lit("ud_w12", wd(12), 12);
    lit("ud_w8", wd(8), 8);
    lit("ud_rnd", W'(bus.rnd), 1);

    do_init(0);
    for (int i = 0; i < 16; i++) begin
      op(1, 0); op(0, 1);
    end
    lit("sat_rnd", W'(bus.rnd), 16);
    lit("sat_done", W'(bus.done), 1);
    op(1, 0);
    lit("sat_rot", wd(12), 15);
    op(0, 1);
    lit("sat_rnd2", W'(bus.rnd), 16);

    do_init(0);
    op(0, 1);
    lit("ill_err", W'(bus.err), 1);
    lit("ill_w12", wd(12), 12);
    op(1, 1);
    lit("ill2_st", W'(bus.diag_st), 0);
    lit("ill2_rnd", W'(bus.rnd), 0);
    do_init(0);
    lit("ill_clr", W'(bus.err), 0);

    op(1, 0);
    rstb = 0; cyc(); rstb = 1;
    lit("mid_w5", wd(5), 0);
    lit("mid_st", W'(bus.diag_st), 0);
    for (int k = 0; k < 16; k++)
      bus.iv[k*W +: W] = W'(k);
    bus.init = 1; bus.ld_mask = 16'h0010;
    bus.diag = 1;
    cyc(); idle();
    lit("pri_w12", wd(12), 12);
    lit("pri_w4", wd(4), 4);
    lit("pri_st", W'(bus.diag_st), 0);

    for (int i = 0; i < 400; i++) begin
      int sel;
      idle();
      sel = $urandom_range(0, 99);
      for (int k = 0; k < 16; k++) begin
        bus.iv[k*W +: W]  = {$urandom, $urandom};
        bus.din[k*W +: W] = {$urandom, $urandom};
      end
      if (sel < 2) rstb = 0;
      else if (sel < 6) bus.init = 1;
      else if (sel < 16)
        bus.ld_mask = 16'($urandom) & 16'($urandom);
      if (sel >= 4 && sel < 45) bus.diag = 1;
      if (sel >= 30 && sel < 90) bus.undiag = 1;
      if (sel >= 40 && sel < 45 && $urandom_range(0, 1) == 1)
        bus.undiag = 0;
      cyc();
      rstb = 1;
    end

    idle(); cyc();
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
